// File: rtl/alu_ctrl_pkg.sv
// Shared constants, ALU control codes and FSM encoding for the shared-ALU controller.
// The ALU_CTR_CHECK_EN build uses ctr_legal() to screen control codes.
package alu_ctrl_pkg;

    localparam int unsigned ALU_W = 32;
    localparam int unsigned CTR_W = 4;

    localparam logic [CTR_W-1:0] ALUCTR_ADD   = 4'b0000;
    localparam logic [CTR_W-1:0] ALUCTR_SLL   = 4'b0001;
    localparam logic [CTR_W-1:0] ALUCTR_SLT   = 4'b0010;
    localparam logic [CTR_W-1:0] ALUCTR_SLTU  = 4'b0011;
    localparam logic [CTR_W-1:0] ALUCTR_XOR   = 4'b0100;
    localparam logic [CTR_W-1:0] ALUCTR_SRL   = 4'b0101;
    localparam logic [CTR_W-1:0] ALUCTR_AND   = 4'b0110;
    localparam logic [CTR_W-1:0] ALUCTR_OR    = 4'b0111;
    localparam logic [CTR_W-1:0] ALUCTR_SUB   = 4'b1000;
    localparam logic [CTR_W-1:0] ALUCTR_SRA   = 4'b1101;
    localparam logic [CTR_W-1:0] ALUCTR_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic ctr_legal(input logic [CTR_W-1:0] ctr);
        case (ctr)
            ALUCTR_ADD, ALUCTR_SLL, ALUCTR_SLT, ALUCTR_SLTU, ALUCTR_XOR, ALUCTR_SRL,
            ALUCTR_AND, ALUCTR_OR, ALUCTR_SUB, ALUCTR_SRA, ALUCTR_PASSB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, ALU and response bundle of the shared-ALU controller.
// rsp_err exists only when ALU_CTR_CHECK_EN is defined.
interface alu_share_ctrl_if
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ALU_W-1:0] req_a;
    logic [NREQ*ALU_W-1:0] req_b;
    logic [NREQ*CTR_W-1:0] req_ctr;

    logic [ALU_W-1:0]      alu_dataa;
    logic [ALU_W-1:0]      alu_datab;
    logic [CTR_W-1:0]      alu_aluctr;
    logic [ALU_W-1:0]      alu_result;
    logic                  alu_zero;
    logic                  alu_less;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [ALU_W-1:0]      rsp_result;
    logic                  rsp_zero;
    logic                  rsp_less;
`ifdef ALU_CTR_CHECK_EN
    logic                  rsp_err;
`endif

    modport master (
        output req_valid, req_a, req_b, req_ctr, rsp_ready,
        output alu_result, alu_zero, alu_less,
        input  req_ready, alu_dataa, alu_datab, alu_aluctr,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_less
`ifdef ALU_CTR_CHECK_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctr, rsp_ready,
        input  alu_result, alu_zero, alu_less,
        output req_ready, alu_dataa, alu_datab, alu_aluctr,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_less
`ifdef ALU_CTR_CHECK_EN
        , output rsp_err
`endif
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  idx_c
);

    // Walk from farthest to nearest so the nearest valid requester overwrites.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        if (enable) begin
            for (int k = int'(NREQ) - 1; k >= 0; k--) begin
                if (req[(int'(ptr) + k) % int'(NREQ)]) begin
                    grant_c = '0;
                    grant_c[(int'(ptr) + k) % int'(NREQ)] = 1'b1;
                    idx_c = IDW'((int'(ptr) + k) % int'(NREQ));
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU among NREQ requesters: round-robin grant, EXEC cycle, held response.
// Define ALU_CTR_CHECK_EN to reject illegal control codes with rsp_err.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_ctrl_if.slave     bus,
    output logic                busy
);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   ptr_nxt;
    logic [NREQ-1:0]  gnt;
    logic             win_c;
    logic             fire_c;
    logic             ok_c;
    logic             rsp_valid_nxt;
    logic [CTR_W-1:0] ctr_g;

    assign win_c = (state == IDLE) || ((state == RESP) && bus.rsp_ready);

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .enable  (win_c),
        .grant_c (gnt),
        .idx_c   (gnt_idx)
    );

    assign bus.req_ready = gnt;
    assign fire_c        = |gnt;
    assign ctr_g         = bus.req_ctr[CTR_W*gnt_idx +: CTR_W];
    assign ptr_nxt       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

`ifdef ALU_CTR_CHECK_EN
    assign ok_c = ctr_legal(ctr_g);
`else
    assign ok_c = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Illegal codes skip EXEC and answer straight from RESP.
    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = bus.rsp_valid;
        case (state)
            IDLE: begin
                if (fire_c) begin
                    state_nxt     = ok_c ? EXEC : RESP;
                    rsp_valid_nxt = !ok_c;
                end
            end
            EXEC: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt     = fire_c ? (ok_c ? EXEC : RESP) : IDLE;
                    rsp_valid_nxt = fire_c && !ok_c;
                end
            end
            default: begin
                state_nxt     = IDLE;
                rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            busy           <= 1'b0;
            bus.alu_dataa  <= '0;
            bus.alu_datab  <= '0;
            bus.alu_aluctr <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_less   <= 1'b0;
`ifdef ALU_CTR_CHECK_EN
            bus.rsp_err    <= 1'b0;
`endif
        end else begin
            busy          <= (state_nxt != IDLE);
            bus.rsp_valid <= rsp_valid_nxt;
            if (fire_c) begin
                bus.rsp_id <= gnt_idx;
                rr_ptr     <= ptr_nxt;
                if (ok_c) begin
                    bus.alu_dataa  <= bus.req_a[ALU_W*gnt_idx +: ALU_W];
                    bus.alu_datab  <= bus.req_b[ALU_W*gnt_idx +: ALU_W];
                    bus.alu_aluctr <= ctr_g;
                end else begin
                    bus.rsp_result <= '0;
                    bus.rsp_zero   <= 1'b0;
                    bus.rsp_less   <= 1'b0;
`ifdef ALU_CTR_CHECK_EN
                    bus.rsp_err    <= 1'b1;
`endif
                end
            end
            if (state == EXEC) begin
                bus.rsp_result <= bus.alu_result;
                bus.rsp_zero   <= bus.alu_zero;
                bus.rsp_less   <= bus.alu_less;
`ifdef ALU_CTR_CHECK_EN
                bus.rsp_err    <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU; ALU_CTR_CHECK_EN adds the illegal-code case.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    logic busy;
    int   total;
    int   bad;

    alu_share_ctrl_if #(.NREQ(2), .IDW(3)) bus ();

    alu_share_ctrl #(.NREQ(2), .IDW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU feeding the controller
    logic [31:0] ra, rb, rr;
    always_comb begin
        ra = bus.alu_dataa;
        rb = bus.alu_datab;
        case (bus.alu_aluctr)
            ALUCTR_ADD:   rr = ra + rb;
            ALUCTR_SLL:   rr = ra << rb[4:0];
            ALUCTR_SLT:   rr = {31'd0, $signed(ra) < $signed(rb)};
            ALUCTR_SLTU:  rr = {31'd0, ra < rb};
            ALUCTR_XOR:   rr = ra ^ rb;
            ALUCTR_SRL:   rr = ra >> rb[4:0];
            ALUCTR_AND:   rr = ra & rb;
            ALUCTR_OR:    rr = ra | rb;
            ALUCTR_SUB:   rr = ra - rb;
            ALUCTR_SRA:   rr = $unsigned($signed(ra) >>> rb[4:0]);
            ALUCTR_PASSB: rr = rb;
            default:      rr = 32'd0;
        endcase
        bus.alu_result = rr;
        bus.alu_zero   = (rr == 32'd0);
        bus.alu_less   = (bus.alu_aluctr == ALUCTR_SLTU) ? (ra < rb) : ($signed(ra) < $signed(rb));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_ctr[4*i +: 4] = c;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctr   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_aluctr", 32'(bus.alu_aluctr), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;

        // single add, requester 0
        set_req(0, 32'd5, 32'd7, ALUCTR_ADD);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b1;
        #1 chk("add_req_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 2'b00;
        chk("add_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("add_exec_busy", 32'(busy), 32'd1);
        chk("add_exec_dataa", bus.alu_dataa, 32'd5);
        step();
        chk("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("add_rsp_result", bus.rsp_result, 32'd12);
        chk("add_rsp_zero", 32'(bus.rsp_zero), 32'd0);
        chk("add_rsp_id", 32'(bus.rsp_id), 32'd0);

        // signed compare, accepted from RESP with rsp_ready high
        set_req(0, 32'hFFFF_FFFF, 32'd1, ALUCTR_SLT);
        bus.req_valid = 2'b01;
        #1 chk("slt_req_ready", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 2'b00;
        chk("slt_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("slt_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("slt_result", bus.rsp_result, 32'd1);
        chk("slt_less", 32'(bus.rsp_less), 32'd1);

        // unsigned compare
        set_req(0, 32'hFFFF_FFFF, 32'd1, ALUCTR_SLTU);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        step();
        chk("sltu_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("sltu_result", bus.rsp_result, 32'd0);
        chk("sltu_less", 32'(bus.rsp_less), 32'd0);
        chk("sltu_zero", 32'(bus.rsp_zero), 32'd1);
        step();
        chk("sltu_idle_busy", 32'(busy), 32'd0);

        // reset during EXEC discards the op
        set_req(0, 32'd1, 32'd2, ALUCTR_OR);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        chk("rmid_exec_aluctr", 32'(bus.alu_aluctr), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("rmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_aluctr", 32'(bus.alu_aluctr), 32'd0);
        chk("rmid_dataa", bus.alu_dataa, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rmid_post_rsp_valid0", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("rmid_post_rsp_valid1", 32'(bus.rsp_valid), 32'd0);

        // fairness: both valid, grants alternate starting at 0
        set_req(0, 32'd10, 32'd3, ALUCTR_SUB);
        set_req(1, 32'd6, 32'd3, ALUCTR_AND);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 chk("fair_req_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk("fair_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("fair_exec_aluctr", 32'(bus.alu_aluctr), (i % 2 == 0) ? 32'd8 : 32'd6);
            step();
            chk("fair_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("fair_rsp_id", 32'(bus.rsp_id), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("fair_rsp_result", bus.rsp_result, (i % 2 == 0) ? 32'd7 : 32'd2);
        end

        // backpressure: response held, no grants
        bus.rsp_ready = 1'b0;
        #1 chk("bp_req_ready0", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_result", bus.rsp_result, 32'd2);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        set_req(1, 32'd12, 32'd10, ALUCTR_OR);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 1'b1;
        #1 chk("bp_release_req_ready", 32'(bus.req_ready), 32'd2);
        step();
        bus.req_valid = 2'b00;
        chk("bp_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("bp_next_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_next_rsp_id", 32'(bus.rsp_id), 32'd1);
        chk("bp_next_rsp_result", bus.rsp_result, 32'd14);
        step();
        chk("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_idle_busy", 32'(busy), 32'd0);

`ifdef ALU_CTR_CHECK_EN
        // illegal code: answered one cycle after accept, ALU operands untouched
        set_req(0, 32'd99, 32'd1, 4'b1010);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        chk("ill_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("ill_rsp_err", 32'(bus.rsp_err), 32'd1);
        chk("ill_rsp_result", bus.rsp_result, 32'd0);
        chk("ill_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("ill_dataa", bus.alu_dataa, 32'd12);
        step();
        chk("ill_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
